slave_interface: RTL and testbench

//   Memory-mapped register bank: the slave side of the VeSPA GPIO peripheral.
//   A bus-side master writes and reads 32-bit registers through independent write and read channels.

---
 rtl/slave_if_pkg.sv | 15 +
 rtl/slave_addr_decode.sv | 16 +
 rtl/slave_interface.sv | 69 ++++++
 tb/tb_slave_interface.sv | 132 +++++++++++++
 4 files changed

// File: rtl/slave_if_pkg.sv
// Shared constants for the GPIO slave register bank: bus widths, register map,
// and the width of the register-index field within a byte address.
package slave_if_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 32;
  localparam int NUM_REGS_DEF   = 8;

  localparam int REG_DATA_OUT = 0;
  localparam int REG_DIR      = 1;
  localparam int REG_DATA_IN  = 2;

  function automatic int idx_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction
endpackage

// File: rtl/slave_addr_decode.sv
// Byte address -> register index plus legality (word aligned, nothing set above
// the index field).
module slave_addr_decode #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = 3
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  legal_o
);
  logic [ADDR_WIDTH-1:0] upper;

  assign idx_o   = addr_i[2 +: IDX_W];
  assign upper   = addr_i >> (2 + IDX_W);
  assign legal_o = (addr_i[1:0] == 2'b00) && (upper == '0);
endmodule

// File: rtl/slave_interface.sv
// GPIO slave register bank: independent write/read channels, registered read
// data and a one-cycle access-error pulse.
module slave_interface
  import slave_if_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    NUM_REGS   = NUM_REGS_DEF,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_WEnable,
  input  logic [ADDR_WIDTH-1:0] i_WAddr,
  input  logic [DATA_WIDTH-1:0] i_WData,
  input  logic                  i_REnable,
  input  logic [ADDR_WIDTH-1:0] i_RAddr,
  output logic [DATA_WIDTH-1:0] o_RData,
  output logic                  o_Err
);
  localparam int IDX_W = idx_width(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DATA_WIDTH-1:0]               rdata_q, rdata_d;
  logic                                err_q, err_d;

  logic [IDX_W-1:0] w_idx, r_idx;
  logic             w_legal, r_legal, w_ro;

  slave_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W)) u_wdec (
    .addr_i (i_WAddr),
    .idx_o  (w_idx),
    .legal_o(w_legal)
  );

  slave_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W)) u_rdec (
    .addr_i (i_RAddr),
    .idx_o  (r_idx),
    .legal_o(r_legal)
  );

  assign w_ro = RO_MASK[w_idx];

  // Read samples regs_q, so a same-cycle write to the same register is not seen.
  always_comb begin
    regs_d  = regs_q;
    rdata_d = rdata_q;
    if (i_WEnable && w_legal && !w_ro)
      regs_d[w_idx] = i_WData;
    if (i_REnable)
      rdata_d = r_legal ? regs_q[r_idx] : '0;
    err_d = (i_WEnable && (!w_legal || w_ro)) || (i_REnable && !r_legal);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      regs_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_RData = rdata_q;
  assign o_Err   = err_q;
endmodule

// File: tb/tb_slave_interface.sv
// Directed bench: each driven cycle queues its expected {rdata, err}; a monitor
// on the falling edge pops and compares against the DUT outputs.
module tb_slave_interface;
  logic        i_Clk, i_Rst, i_WEnable, i_REnable;
  logic [31:0] i_WAddr, i_WData, i_RAddr;
  logic [31:0] o_RData;
  logic        o_Err;

  slave_interface #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(8), .RO_MASK(8'h04)
  ) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_WEnable(i_WEnable),
    .i_WAddr  (i_WAddr),
    .i_WData  (i_WData),
    .i_REnable(i_REnable),
    .i_RAddr  (i_RAddr),
    .o_RData  (o_RData),
    .o_Err    (o_Err)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge i_Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (o_RData !== e.rd || o_Err !== e.err) begin
        errors++;
        $display("FAIL %s: got rdata=%h err=%b, want rdata=%h err=%b",
                 e.name, o_RData, o_Err, e.rd, e.err);
      end
    end
  end

  task automatic acc(input string nm, input logic we, input logic [31:0] wa,
                     input logic [31:0] wd, input logic re, input logic [31:0] ra,
                     input logic [31:0] erd, input logic eerr);
    exp_t e;
    i_Rst = 1'b1; i_WEnable = we; i_WAddr = wa; i_WData = wd;
    i_REnable = re; i_RAddr = ra;
    @(posedge i_Clk);
    e.rd = erd; e.err = eerr; e.name = nm;
    sb.push_back(e);
    #1;
  endtask

  // Reset cycle with arbitrary (possibly illegal) accesses alongside.
  task automatic rst(input string nm, input logic we, input logic [31:0] wa,
                     input logic re, input logic [31:0] ra);
    exp_t e;
    i_Rst = 1'b0; i_WEnable = we; i_WAddr = wa; i_WData = 32'hDEADBEEF;
    i_REnable = re; i_RAddr = ra;
    @(posedge i_Clk);
    e.rd = 32'h0; e.err = 1'b0; e.name = nm;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    i_Rst = 1'b0; i_WEnable = 1'b0; i_REnable = 1'b0;
    i_WAddr = '0; i_WData = '0; i_RAddr = '0;

    // 1: reset, then every register reads 0
    rst("reset0", 1'b0, 32'h0, 1'b0, 32'h0);
    rst("reset1", 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++)
      acc($sformatf("post_reset_rd%0d", i), 1'b0, 32'h0, 32'h0, 1'b1, 32'(i*4), 32'h0, 1'b0);

    // 2: basic write then read
    acc("wr0_aa55", 1'b1, 32'h0, 32'hAA55AA55, 1'b0, 32'h0, 32'h0, 1'b0);
    acc("rd0_aa55", 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'hAA55AA55, 1'b0);
    acc("idle_hold", 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'hAA55AA55, 1'b0);

    // 3: distinct value per register (register 2 is read-only)
    for (int i = 0; i < 8; i++)
      acc($sformatf("wr_all%0d", i), 1'b1, 32'(i*4), 32'hC0DE0000 + 32'(i),
          1'b0, 32'h0, 32'hAA55AA55, (i == 2));
    for (int i = 0; i < 8; i++)
      acc($sformatf("rd_all%0d", i), 1'b0, 32'h0, 32'h0, 1'b1, 32'(i*4),
          (i == 2) ? 32'h0 : 32'hC0DE0000 + 32'(i), 1'b0);

    // 4: illegal addresses
    acc("rd_misalign", 1'b0, 32'h0, 32'h0, 1'b1, 32'h02, 32'h0, 1'b1);
    acc("err_clears",  1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    acc("wr_oor",      1'b1, 32'h20, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b1);
    acc("wr_misalign", 1'b1, 32'h06, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b1);
    acc("wr_highbit",  1'b1, 32'h80000004, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b1);
    acc("rd_after_bad_wr", 1'b0, 32'h0, 32'h0, 1'b1, 32'h04, 32'hC0DE0001, 1'b0);
    acc("rd_oor",      1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 32'h0, 1'b1);
    acc("rd_wr_both_bad", 1'b1, 32'h21, 32'h1, 1'b1, 32'h03, 32'h0, 1'b1);
    acc("disabled_bad_addr", 1'b0, 32'h22, 32'h1, 1'b0, 32'h41, 32'h0, 1'b0);
    acc("rd_reg1_kept", 1'b0, 32'h0, 32'h0, 1'b1, 32'h04, 32'hC0DE0001, 1'b0);
    acc("rd_reg0_kept", 1'b0, 32'h0, 32'h0, 1'b1, 32'h00, 32'hC0DE0000, 1'b0);

    // 6: read-only register and mid-sequence reset
    acc("wr_ro8",   1'b1, 32'h08, 32'h55555555, 1'b0, 32'h0, 32'hC0DE0000, 1'b1);
    acc("rd_ro8",   1'b0, 32'h0, 32'h0, 1'b1, 32'h08, 32'h0, 1'b0);
    rst("reset_mid", 1'b1, 32'h00, 1'b1, 32'h02);
    acc("rd0_after_rst", 1'b0, 32'h0, 32'h0, 1'b1, 32'h00, 32'h0, 1'b0);
    acc("rd7_after_rst", 1'b0, 32'h0, 32'h0, 1'b1, 32'h1C, 32'h0, 1'b0);

    // 5: same-cycle read/write returns the old value
    acc("rw_same_cycle", 1'b1, 32'h04, 32'h12345678, 1'b1, 32'h04, 32'h0, 1'b0);
    acc("rd_next_cycle", 1'b0, 32'h0, 32'h0, 1'b1, 32'h04, 32'h12345678, 1'b0);
    acc("wr_rd_other", 1'b1, 32'h1C, 32'h0BADF00D, 1'b1, 32'h04, 32'h12345678, 1'b0);
    acc("rd7_new",     1'b0, 32'h0, 32'h0, 1'b1, 32'h1C, 32'h0BADF00D, 1'b0);

    i_WEnable = 1'b0; i_REnable = 1'b0;
    for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge i_Clk);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
